// File: rtl/vco_adc_pkg.sv
// Shared widths and arithmetic helpers for the multi-phase VCO-ADC quantiser back end.
package vco_adc_pkg;

  localparam int unsigned PHASES_DEF = 15;
  localparam int unsigned DECIM_DEF  = 16;
  localparam int unsigned OUT_W_DEF  = 8;
  localparam int unsigned POP_MAX_W  = 64;

  // Window counter never narrower than one bit, even when DECIM is 1
  function automatic int unsigned cnt_width(input int unsigned decim);
    return (decim > 1) ? $clog2(decim) : 1;
  endfunction

  function automatic int unsigned delta_width(input int unsigned phases);
    return (phases > 0) ? $clog2(phases + 1) : 1;
  endfunction

  localparam int unsigned CNT_W   = cnt_width(DECIM_DEF);
  localparam int unsigned DELTA_W = delta_width(PHASES_DEF);

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(POP_MAX_W); i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // Unsigned add clipped to 2**w-1 rather than wrapping
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = 33'(a) + 33'(b);
    lim = (33'(1) << w) - 33'(1);
    return (sum > lim) ? 32'(lim) : 32'(sum);
  endfunction

endpackage

// File: rtl/vco_phase_sync.sv
// Samples the asynchronous VCO taps and reports how many taps changed since last cycle.
// Define VCO_SYNC2_EN to add a second synchroniser stage (one extra cycle of latency).
module vco_phase_sync
  import vco_adc_pkg::*;
#(
  parameter  int unsigned PHASES = PHASES_DEF,
  localparam int unsigned DLT_W  = delta_width(PHASES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PHASES-1:0] phase_in,
  output logic [DLT_W-1:0]  delta_c
);

  logic [PHASES-1:0] s1;
  logic [PHASES-1:0] sync;
  logic [PHASES-1:0] prev;

`ifdef VCO_SYNC2_EN
  logic [PHASES-1:0] s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= phase_in;
      s2 <= s1;
    end
  end

  assign sync = s2;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1 <= phase_in;
    end
  end

  assign sync = s1;
`endif

  // prev tracks sync regardless of enable so the first enabled cycle is a true difference
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= sync;
    end
  end

  always_comb begin
    delta_c = DLT_W'(popcount(POP_MAX_W'(sync ^ prev)));
  end

endmodule

// File: rtl/vco_phase_counter.sv
// VCO-ADC back end: accumulates per-cycle tap transitions over DECIM cycles and emits a code.
// Synchroniser depth selected by VCO_SYNC2_EN (see vco_phase_sync).
module vco_phase_counter
  import vco_adc_pkg::*;
#(
  parameter int unsigned PHASES = PHASES_DEF,
  parameter int unsigned DECIM  = DECIM_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PHASES-1:0] phase_in,
  input  logic              en,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int unsigned      WIN_W    = cnt_width(DECIM);
  localparam int unsigned      DLT_W    = delta_width(PHASES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DECIM - 1);

  logic [DLT_W-1:0] delta_c;
  logic [OUT_W-1:0] acc;
  logic [WIN_W-1:0] win_cnt;
  logic [OUT_W-1:0] sum_c;
  logic             win_done_c;
  logic             deliver_c;

  vco_phase_sync #(
    .PHASES (PHASES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase_in (phase_in),
    .delta_c  (delta_c)
  );

  // Window close and whether the output slot can take the result this edge
  always_comb begin
    sum_c      = OUT_W'(sat_add(32'(acc), 32'(delta_c), OUT_W));
    win_done_c = 1'b0;
    deliver_c  = 1'b0;
    if (en && (win_cnt == WIN_LAST)) begin
      win_done_c = 1'b1;
      deliver_c  = !out_valid || out_ready;
    end
  end

  // Disabling discards the partial window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (!en || win_done_c) begin
      acc     <= '0;
      win_cnt <= '0;
    end else begin
      acc     <= sum_c;
      win_cnt <= win_cnt + WIN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (deliver_c) begin
      out_data  <= sum_c;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky drop flag; a clear wins over a same-cycle drop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end else if (win_done_c && !deliver_c) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vco_phase_counter.sv
// Scoreboard bench for vco_phase_counter: default 8-bit build plus a 6-bit saturating instance.
`timescale 1ns/1ps
module tb_vco_phase_counter;

  localparam logic [14:0] ALL = 15'h7FFF;
`ifdef VCO_SYNC2_EN
  localparam int unsigned RST_CODE = 210;
`else
  localparam int unsigned RST_CODE = 225;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        out_ready;
  logic        ovf_clr;
  logic [14:0] phase_in;
  logic [14:0] tog_mask;

  logic [7:0]  d8_data;
  logic        d8_valid;
  logic        d8_ovf;
  logic [5:0]  d6_data;
  logic        d6_valid;
  logic        d6_ovf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned q8[$];
  int unsigned q6[$];

  always #5 clk = ~clk;

  vco_phase_counter dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_in  (phase_in),
    .en        (en),
    .out_data  (d8_data),
    .out_valid (d8_valid),
    .out_ready (out_ready),
    .ovf       (d8_ovf),
    .ovf_clr   (ovf_clr)
  );

  vco_phase_counter #(.OUT_W(6)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_in  (phase_in),
    .en        (en),
    .out_data  (d6_data),
    .out_valid (d6_valid),
    .out_ready (out_ready),
    .ovf       (d6_ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected code for the 8-bit instance; the 6-bit one clips at 63
  task automatic push(input int unsigned v);
    q8.push_back(v);
    q6.push_back((v > 63) ? 63 : v);
  endtask

  // Inputs change just after the active edge; taps in tog_mask flip every cycle
  task automatic cyc();
    @(posedge clk);
    #1;
    phase_in = phase_in ^ tog_mask;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Monitors: a handshake seen mid-cycle completes at the next posedge
  always @(negedge clk) begin
    if (rst_n && d8_valid && out_ready) begin
      if (q8.size() == 0) check("d8_unexpected_code", 32'(d8_data), 32'hFFFF_FFFF);
      else check("d8_code", 32'(d8_data), q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && d6_valid && out_ready) begin
      if (q6.size() == 0) check("d6_unexpected_code", 32'(d6_data), 32'hFFFF_FFFF);
      else check("d6_code", 32'(d6_data), q6.pop_front());
    end
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    phase_in  = 15'h1555;
    tog_mask  = '0;
    run(3);
    check("rst_d8_data", 32'(d8_data), 0);
    check("rst_d8_valid", 32'(d8_valid), 0);
    check("rst_d8_ovf", 32'(d8_ovf), 0);
    check("rst_d6_valid", 32'(d6_valid), 0);

    // Constant taps: 7 high taps counted once after reset, then silence
    push(7); push(0); push(0);
    rst_n = 1'b1;
    en    = 1'b1;
    run(48);
    en = 1'b0;
    run(4);

    // One tap toggling every cycle
    tog_mask = 15'h0001;
    run(3);
    push(16); push(16);
    en = 1'b1;
    run(32);
    en = 1'b0;
    run(4);

    // All taps toggling: 240, clipped to 63 on the narrow instance
    tog_mask = ALL;
    run(3);
    push(240); push(240);
    en = 1'b1;
    run(32);
    en = 1'b0;
    run(4);

    // Partial window discarded by an enable gap
    push(240);
    en = 1'b1;
    run(10);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(16);
    en = 1'b0;
    run(4);

    // Backpressure: second window dropped, ovf set, first code held
    push(240);
    out_ready = 1'b0;
    en        = 1'b1;
    run(32);
    en = 1'b0;
    check("bp_d8_ovf_set", 32'(d8_ovf), 1);
    check("bp_d6_ovf_set", 32'(d6_ovf), 1);
    check("bp_d8_valid_held", 32'(d8_valid), 1);
    check("bp_d8_data_held", 32'(d8_data), 240);
    check("bp_d6_data_held", 32'(d6_data), 63);
    run(4);
    ovf_clr = 1'b1;
    run(1);
    ovf_clr = 1'b0;
    check("bp_d8_ovf_clr", 32'(d8_ovf), 0);
    check("bp_d6_ovf_clr", 32'(d6_ovf), 0);
    check("bp_d8_valid_after_clr", 32'(d8_valid), 1);
    run(3);
    out_ready = 1'b1;
    run(4);
    check("bp_d8_drained", 32'(d8_valid), 0);
    check("bp_d8_data_kept", 32'(d8_data), 240);

    // Reset at win_cnt=8, then one full window from a known tap state
    tog_mask = '0;
    phase_in = '0;
    run(3);
    tog_mask = ALL;
    en       = 1'b1;
    run(8);
    rst_n = 1'b0;
    run(1);
    check("midrst_d8_data", 32'(d8_data), 0);
    check("midrst_d8_valid", 32'(d8_valid), 0);
    check("midrst_d8_ovf", 32'(d8_ovf), 0);
    check("midrst_d6_data", 32'(d6_data), 0);
    rst_n = 1'b1;
    push(RST_CODE);
    run(15);
    check("midrst_no_early_code", 32'(d8_valid), 0);
    run(1);
    en = 1'b0;
    run(8);

    check("d8_queue_empty", q8.size(), 0);
    check("d6_queue_empty", q6.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
